board_io_wb: RTL and testbench
==============================

Name: board_io_wb

Overview:
- Wishbone classic slave giving the processor data bus register access to on-board I/O: LEDs, N seven-segment digits, switches and push-buttons.
- Replaces the hard-wired switch/LED/seven-segment glue at top level.
- Generalised in digit, LED, switch and button count.
- Adds debouncing, sticky button-press events with an interrupt, per-digit blank/decimal-point/blink, and selectable segment polarity.

Parameters:
NUM_DIGITS, 4, seven-segment digits (1..8)
NUM_LEDS, 10, LED outputs (1..32)
NUM_SWITCHES, 10, switch inputs (1..16)
NUM_BUTTONS, 3, button inputs (1..16)
BUTTON_ACTIVE_LOW, 1, 1 = pin low means pressed
SEG_ACTIVE_LOW, 1, 1 = segment lit when pin is 0
DEBOUNCE_CYCLES, 500000, stable cycles before an input change is accepted (10 ms at 50 MHz)
BLINK_CYCLES, 25000000, cycles per blink half-period

Ports:
clk_i  in  1  bus clock; everything is synchronous to it
rst_i  in  1  asynchronous, active-high reset
cyc_i  in  1  Wishbone cycle
stb_i  in  1  Wishbone strobe
we_i  in  1  write enable
adr_i  in  5  byte address; bits [4:2] decoded
sel_i  in  4  byte-lane selects
dat_i  in  32  write data
dat_o  out  32  read data
ack_o  out  1  acknowledge
irq_o  out  1  level interrupt
switches  in  NUM_SWITCHES  raw switch pins
buttons  in  NUM_BUTTONS  raw button pins
leds  out  NUM_LEDS  LED drive
seg7  out  8*NUM_DIGITS  digit i = [8i+7:8i]; bit 7 = dp, [6:0] = segments a..g

Behaviour:
- Clocking and reset: one clock (clk_i). Reset is asynchronous and active-high (rst_i).
- Bus protocol:
  - ack_o asserts on the cycle after cyc_i&stb_i is sampled with ack_o low.
  - ack_o is held one cycle, then drops, so back-to-back accesses take 2 cycles each.
  - No wait states beyond this; no err/rty.
  - Writes honour sel_i per byte; unselected bytes are unchanged.
  - dat_o is registered with ack_o.
  - Unmapped addresses read 0, ignore writes, and still ack.
- Register map (adr_i[4:2]):
  - 0 LED, RW: bits [NUM_LEDS-1:0] drive leds directly (registered).
  - 1 HEX, RW: nibble i = hex value of digit i.
  - 2 DISP, RW: [7:0] blank mask, [15:8] dp, [23:16] blink enable; bits at or above NUM_DIGITS in each field read 0.
  - 3 INPUT, RO: [15:0] debounced switches, [31:16] debounced buttons (1 = pressed).
  - 4 EVENT, RW1C: bit j set on a debounced press (0→1) of button j.
  - 5 IRQMASK, RW: [NUM_BUTTONS-1:0].
  - All unused bits read 0.
- Reset values:
  - LED=0, HEX=0, DISP blank mask all ones (display dark), dp=0, blink=0, EVENT=0, IRQMASK=0.
  - Debounced state 0 (released/off), counters 0, blink phase = on.
  - Outputs: ack_o=0, dat_o=0, irq_o=0, leds=0, every seg7 segment off (all 1s if SEG_ACTIVE_LOW).
- Input conditioning:
  - Every input passes through a 2-flop synchroniser; buttons are inverted first when BUTTON_ACTIVE_LOW.
  - Each input has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synced value equals stable value → counter cleared.
  - Synced value differs → counter increments. On reaching DEBOUNCE_CYCLES-1 the stable value takes the synced value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count.
  - Latency from pin to INPUT: 2 + DEBOUNCE_CYCLES cycles.
- Events:
  - EVENT bit sets on the cycle the stable button value goes 0→1.
  - Writing 1 clears the bit; writing 0 has no effect.
  - A set and a clear in the same cycle: set wins.
  - Release does nothing.
- Interrupt: irq_o = |(EVENT & IRQMASK), registered, so it is 1 cycle after the contributing bit changes.
- Display:
  - A free-running blink counter toggles the blink phase every BLINK_CYCLES cycles and wraps to 0.
  - Digit i is dark when blank[i], or when blink[i] and the phase is off.
  - Otherwise segments = hex decode of nibble i (0-F, standard a..g patterns), and dp = dp[i]. The dp follows the same dark rule.
  - Polarity is applied last. seg7 is registered: 1 cycle after the register write.
- Reset mid-access: ack_o drops immediately and any in-flight write is lost.

Test Plan:
1. Reset, then read all registers → LED=0, HEX=0, DISP=0x0000000F (4 digits), INPUT=0, EVENT=0, IRQMASK=0. seg7=0xFFFFFFFF, irq_o=0.
2. Write HEX=0x0000A5C3 and DISP=0x00000200 (sel=4'hF) → seg7 digit0 shows "3", digit1 "C" with dp lit, digit2 "5", digit3 "A", 1 cycle after ack. Write sel=4'h1 with dat=0xFFFFFF07 to HEX → HEX reads 0x0000A507.
3. With DEBOUNCE_CYCLES=4: button0 pin held low for 3 cycles then high → INPUT stays 0, EVENT=0. Held low for 10 cycles → INPUT[16]=1, EVENT=1. With IRQMASK=1, irq_o=1.
4. EVENT=1 pending: W1C write of 1 on the same cycle a new button0 press is accepted → EVENT stays 1. A later W1C write of 1 → EVENT=0, irq_o=0 one cycle after.
5. BLINK_CYCLES=8, DISP=0x00010000 → digit0 alternates lit/dark every 8 cycles; digits 1-3 stay lit.
6. Assert rst_i during a write cycle (ack pending) → ack_o=0 at once, register unchanged (reset values), seg7 all dark.

Source files
------------

// File: rtl/board_io_wb_if.sv
// Wishbone classic bus bundle for the on-board I/O register block.
// The slave side receives the request and returns data, ack and the interrupt.
interface board_io_wb_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [4:0]  adr_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        irq_o;

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      output dat_o, ack_o, irq_o
   );

   modport master (
      output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
      input  dat_o, ack_o, irq_o
   );
endinterface

// File: rtl/board_io_wb.sv
// Wishbone slave for board I/O: LEDs, seven-segment digits, debounced
// switches/buttons, sticky button events with a maskable level interrupt.
module board_io_wb #(
   parameter int NUM_DIGITS        = 4,
   parameter int NUM_LEDS          = 10,
   parameter int NUM_SWITCHES      = 10,
   parameter int NUM_BUTTONS       = 3,
   parameter int BUTTON_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW    = 1,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int BLINK_CYCLES      = 25000000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   board_io_wb_if.slave            bus,
   input  logic [NUM_SWITCHES-1:0] switches,
   input  logic [NUM_BUTTONS-1:0]  buttons,
   output logic [NUM_LEDS-1:0]     leds,
   output logic [8*NUM_DIGITS-1:0] seg7
);
   localparam int   NIN     = NUM_SWITCHES + NUM_BUTTONS;
   localparam int   CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int   BW      = $clog2(BLINK_CYCLES + 1);
   localparam int   HW      = 4 * NUM_DIGITS;
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   logic [NIN-1:0]          raw, s1_q, s2_q, stab_q, stab_d;
   logic [CW-1:0]           cnt_q [NIN];
   logic [CW-1:0]           cnt_d [NIN];
   logic [NUM_LEDS-1:0]     led_q, led_d;
   logic [HW-1:0]           hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d, dp_q, dp_d, blink_q, blink_d;
   logic [NUM_BUTTONS-1:0]  evt_q, evt_d, evt_clr, mask_q, mask_d, press;
   logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
   logic [31:0]             dat_q, rdata;
   logic [BW-1:0]           bcnt_q;
   logic                    phase_q, ack_q, irq_q, acc, wr;
   logic                    unused_ok;

   // Buttons are normalised to 1 = pressed before synchronising.
   assign raw = {(BUTTON_ACTIVE_LOW != 0) ? ~buttons : buttons, switches};
   assign acc = bus.cyc_i & bus.stb_i & ~ack_q;
   assign wr  = acc & bus.we_i;

   always_comb begin
      stab_d = stab_q;
      for (int i = 0; i < NIN; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stab_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) stab_d[i] = s2_q[i];
            else                                      cnt_d[i]  = cnt_q[i] + 1'b1;
         end
      end
   end

   assign press = stab_d[NIN-1:NUM_SWITCHES] & ~stab_q[NIN-1:NUM_SWITCHES];

   always_comb begin
      led_d   = led_q;
      hex_d   = hex_q;
      blank_d = blank_q;
      dp_d    = dp_q;
      blink_d = blink_q;
      mask_d  = mask_q;
      evt_clr = '0;
      if (wr) begin
         case (bus.adr_i[4:2])
            3'd0: for (int b = 0; b < NUM_LEDS; b++)
                     if (bus.sel_i[b/8]) led_d[b] = bus.dat_i[b];
            3'd1: for (int b = 0; b < HW; b++)
                     if (bus.sel_i[b/8]) hex_d[b] = bus.dat_i[b];
            3'd2: for (int i = 0; i < NUM_DIGITS; i++) begin
                     if (bus.sel_i[0]) blank_d[i] = bus.dat_i[i];
                     if (bus.sel_i[1]) dp_d[i]    = bus.dat_i[8+i];
                     if (bus.sel_i[2]) blink_d[i] = bus.dat_i[16+i];
                  end
            3'd4: for (int j = 0; j < NUM_BUTTONS; j++)
                     if (bus.sel_i[j/8]) evt_clr[j] = bus.dat_i[j];
            3'd5: for (int j = 0; j < NUM_BUTTONS; j++)
                     if (bus.sel_i[j/8]) mask_d[j] = bus.dat_i[j];
            default: ;
         endcase
      end
      // A press accepted in the same cycle as a clear keeps the bit set.
      evt_d = (evt_q & ~evt_clr) | press;
   end

   always_comb begin
      case (bus.adr_i[4:2])
         3'd0:    rdata = 32'(led_q);
         3'd1:    rdata = 32'(hex_q);
         3'd2:    rdata = {8'h00, 8'(blink_q), 8'(dp_q), 8'(blank_q)};
         3'd3:    rdata = {16'(stab_q[NIN-1:NUM_SWITCHES]), 16'(stab_q[NUM_SWITCHES-1:0])};
         3'd4:    rdata = 32'(evt_q);
         3'd5:    rdata = 32'(mask_q);
         default: rdata = '0;
      endcase
   end

   always_comb begin
      logic [7:0] pat;
      seg_d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         pat = '0;
         if (!(blank_q[i] || (blink_q[i] && !phase_q)))
            pat = {dp_q[i], hex7(hex_q[4*i +: 4])};
         seg_d[8*i +: 8] = SEG_INV ? ~pat : pat;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q    <= '0;
         s2_q    <= '0;
         stab_q  <= '0;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
         led_q   <= '0;
         hex_q   <= '0;
         blank_q <= '1;
         dp_q    <= '0;
         blink_q <= '0;
         evt_q   <= '0;
         mask_q  <= '0;
         irq_q   <= 1'b0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b1;
         seg_q   <= {(8*NUM_DIGITS){SEG_INV}};
      end else begin
         s1_q    <= raw;
         s2_q    <= s1_q;
         stab_q  <= stab_d;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
         led_q   <= led_d;
         hex_q   <= hex_d;
         blank_q <= blank_d;
         dp_q    <= dp_d;
         blink_q <= blink_d;
         evt_q   <= evt_d;
         mask_q  <= mask_d;
         irq_q   <= |(evt_q & mask_q);
         ack_q   <= acc;
         dat_q   <= acc ? rdata : '0;
         if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
         end else begin
            bcnt_q  <= bcnt_q + 1'b1;
         end
         seg_q   <= seg_d;
      end
   end

   assign bus.ack_o = ack_q;
   assign bus.dat_o = dat_q;
   assign bus.irq_o = irq_q;
   assign leds      = led_q;
   assign seg7      = seg_q;
   assign unused_ok = ^{bus.adr_i[1:0], bus.sel_i, bus.dat_i};
endmodule

// File: tb/tb_board_io_wb.sv
// Directed bench for board_io_wb with short debounce and blink periods.
module tb_board_io_wb;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  switches;
   logic [2:0]  buttons;
   logic [9:0]  leds;
   logic [31:0] seg7;
   logic [31:0] q;
   logic [7:0]  d0 [24];
   int          vecs = 0;
   int          errs = 0;

   board_io_wb_if bus();

   board_io_wb #(
      .NUM_DIGITS(4), .NUM_LEDS(10), .NUM_SWITCHES(10), .NUM_BUTTONS(3),
      .BUTTON_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1),
      .DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)
   ) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus),
      .switches(switches), .buttons(buttons), .leds(leds), .seg7(seg7)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the ack cycle.
   task automatic wb(input logic w, input logic [2:0] r, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rq);
      logic got;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = w;
      bus.adr_i = {r, 2'b00}; bus.sel_i = s; bus.dat_i = d;
      got = 1'b0;
      for (int n = 0; n < 4 && !got; n++) begin
         @(posedge clk); #1;
         if (bus.ack_o) got = 1'b1;
      end
      rq = bus.dat_o;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      chk("ack", 64'(got), 64'd1);
   endtask

   task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb(1'b1, r, d, s, dummy);
   endtask

   task automatic rdc(input string tag, input logic [2:0] r, input logic [31:0] exp);
      logic [31:0] rq;
      wb(1'b0, r, 32'h0, 4'hF, rq);
      chk(tag, 64'(rq), 64'(exp));
   endtask

   initial begin
      rst = 1'b1; switches = '0; buttons = 3'b111;
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = '0; bus.sel_i = '0; bus.dat_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_ack", 64'(bus.ack_o), 0);
      chk("rst_dat", 64'(bus.dat_o), 0);
      chk("rst_irq", 64'(bus.irq_o), 0);
      chk("rst_leds", 64'(leds), 0);
      chk("rst_seg", 64'(seg7), 64'hFFFFFFFF);
      rdc("rst_LED", 3'd0, 32'h0);
      rdc("rst_HEX", 3'd1, 32'h0);
      rdc("rst_DISP", 3'd2, 32'h0000000F);
      rdc("rst_INPUT", 3'd3, 32'h0);
      rdc("rst_EVENT", 3'd4, 32'h0);
      rdc("rst_MASK", 3'd5, 32'h0);

      // display and byte-lane writes
      wr(3'd1, 32'h0000A5C3, 4'hF);
      wr(3'd2, 32'h00000200, 4'hF);
      chk("seg_lag", 64'(seg7), 64'hFFFFFFFF);
      @(posedge clk); #1;
      chk("seg_hex", 64'(seg7), 64'h889246B0);
      wr(3'd1, 32'hFFFFFF07, 4'h1);
      rdc("HEX_sel", 3'd1, 32'h0000A507);
      wr(3'd2, 32'hFFFFFFFF, 4'hF);
      rdc("DISP_mask", 3'd2, 32'h000F0F0F);
      wr(3'd2, 32'h00000200, 4'hF);
      wr(3'd0, 32'hFFFFFFFF, 4'hF);
      rdc("LED_rd", 3'd0, 32'h000003FF);
      chk("leds", 64'(leds), 64'h3FF);
      wr(3'd0, 32'h00000155, 4'h2);
      rdc("LED_sel", 3'd0, 32'h000001FF);
      wr(3'd7, 32'hFFFFFFFF, 4'hF);
      rdc("unmapped", 3'd7, 32'h0);

      // debounce: short glitch rejected, long press accepted
      buttons[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 buttons[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rdc("glitch_IN", 3'd3, 32'h0);
      rdc("glitch_EV", 3'd4, 32'h0);
      switches = 10'h2A5; buttons[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rdc("press_IN", 3'd3, 32'h000102A5);
      rdc("press_EV", 3'd4, 32'h1);
      chk("irq_masked", 64'(bus.irq_o), 0);
      wr(3'd5, 32'h1, 4'hF);
      @(posedge clk); #1;
      chk("irq_on", 64'(bus.irq_o), 1);
      rdc("MASK_rd", 3'd5, 32'h1);
      buttons[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rdc("release_EV", 3'd4, 32'h1);
      rdc("release_IN", 3'd3, 32'h000002A5);

      // W1C: write 0 no effect; clear colliding with a new press loses
      wr(3'd4, 32'h0, 4'hF);
      rdc("w0_EV", 3'd4, 32'h1);
      buttons[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      wr(3'd4, 32'h1, 4'hF);
      rdc("setwins_EV", 3'd4, 32'h1);
      rdc("setwins_IN", 3'd3, 32'h000102A5);
      chk("setwins_irq", 64'(bus.irq_o), 1);
      buttons[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      wr(3'd4, 32'h1, 4'hF);
      chk("irq_lag", 64'(bus.irq_o), 1);
      @(posedge clk); #1;
      chk("irq_off", 64'(bus.irq_o), 0);
      rdc("clr_EV", 3'd4, 32'h0);

      // blink on digit 0 only
      wr(3'd2, 32'h00010000, 4'hF);
      @(posedge clk); #1;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk); #1;
         d0[k] = seg7[7:0];
         chk("blink_upper", 64'(seg7[31:8]), 64'h8892C0);
         chk("blink_d0val", 64'((d0[k] == 8'hF8) || (d0[k] == 8'hFF)), 1);
      end
      for (int k = 0; k < 16; k++)
         chk("blink_period", 64'(d0[k+8]), (d0[k] == 8'hF8) ? 64'hFF : 64'hF8);

      // reset with ack high, then reset before the write edge
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = 5'h00; bus.sel_i = 4'hF; bus.dat_i = 32'h155;
      @(posedge clk); #1;
      chk("pre_rst_ack", 64'(bus.ack_o), 1);
      rst = 1'b1;
      #1;
      chk("rst_ack_drop", 64'(bus.ack_o), 0);
      chk("rst_leds2", 64'(leds), 0);
      chk("rst_seg2", 64'(seg7), 64'hFFFFFFFF);
      chk("rst_dat2", 64'(bus.dat_o), 0);
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
      @(posedge clk); #1 rst = 1'b0;
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.dat_i = 32'h2AA;
      #3 rst = 1'b1;
      #1;
      chk("rst_inflight_ack", 64'(bus.ack_o), 0);
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
      @(posedge clk); #1 rst = 1'b0;
      rdc("rst_LED2", 3'd0, 32'h0);
      rdc("rst_DISP2", 3'd2, 32'h0000000F);
      rdc("rst_HEX2", 3'd1, 32'h0);
      rdc("rst_EV2", 3'd4, 32'h0);
      chk("rst_seg3", 64'(seg7), 64'hFFFFFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
